// File: rtl/seq1100_pkg.sv
// Shared types and constants for the 1100-sync serial link.
package seq1100_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

  localparam logic [3:0] SYNC_WORD  = 4'b1100;
  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [2:0] HIST_RESET = 3'b111;
endpackage

// File: rtl/seq1100_framer_tx_if.sv
// Producer-side handshake plus serial-line outputs of the 1100 framer.
interface seq1100_framer_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ser_out;
  logic              sync_active;
  logic              busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, ser_out, sync_active, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, ser_out, sync_active, busy
  );
endinterface

// File: rtl/seq1100_stuff_guard.sv
// Tracks the last three line bits and requests a stuffed 1 after 110,
// so a 1100 pattern can never form outside a sync word.
module seq1100_stuff_guard
  import seq1100_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_out,
  input  logic shift_en,
  input  logic stuff_allow,
  output logic stuff_req
);
  logic [2:0] hist_q;
  logic [2:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (shift_en) hist_d = {hist_q[1:0], bit_out};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= HIST_RESET;
    else        hist_q <= hist_d;
  end

  assign stuff_req = stuff_allow && (hist_q == 3'b110);
endmodule

// File: rtl/seq1100_framer_tx.sv
// Serializes DATA_W-bit words as 1100 sync + MSB-first payload with bit stuffing.
// Optional even-parity trailer bit when SEQ1100_TX_PARITY_EN is defined.
module seq1100_framer_tx
  import seq1100_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq1100_framer_tx_if.slave        bus
);
  localparam int CNT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              ser_out_q, ser_out_d;
  logic              sync_active_q, sync_active_d;
  logic              busy_q, busy_d;
  logic              tx_ready_q, tx_ready_d;
  logic              shift_en;
  logic              stuff_allow;
  logic              stuff_req;

  seq1100_stuff_guard u_guard (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_out     (ser_out_d),
    .shift_en    (shift_en),
    .stuff_allow (stuff_allow),
    .stuff_req   (stuff_req)
  );

  assign stuff_allow = (state_q == DATA) || (state_q == PAR);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    ser_out_d     = IDLE_LEVEL;
    sync_active_d = 1'b0;
    busy_d        = 1'b0;
    tx_ready_d    = 1'b0;
    shift_en      = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        // The accept edge already drives the first sync bit, giving a single idle bit between frames.
        if (bus.tx_valid && tx_ready_q) begin
          tx_ready_d    = 1'b0;
          shreg_d       = bus.tx_data;
          par_d         = ^bus.tx_data;
          ser_out_d     = SYNC_WORD[3];
          sync_active_d = 1'b1;
          busy_d        = 1'b1;
          shift_en      = 1'b1;
          cnt_d         = CNT_W'(1);
          state_d       = SYNC;
        end
      end
      SYNC: begin
        ser_out_d     = SYNC_WORD[2'd3 - cnt_q[1:0]];
        sync_active_d = 1'b1;
        busy_d        = 1'b1;
        shift_en      = 1'b1;
        if (cnt_q == CNT_W'(3)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        busy_d   = 1'b1;
        shift_en = 1'b1;
        // A stuffed 1 holds the payload bit and the counter for one line bit.
        if (!stuff_req) begin
          ser_out_d = shreg_q[DATA_W-1];
          shreg_d   = shreg_q << 1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef SEQ1100_TX_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PAR: begin
        busy_d   = 1'b1;
        shift_en = 1'b1;
        if (!stuff_req) begin
          ser_out_d = par_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ser_out_q     <= IDLE_LEVEL;
      sync_active_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      sync_active_q <= sync_active_d;
      busy_q        <= busy_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.ser_out     = ser_out_q;
  assign bus.sync_active = sync_active_q;
  assign bus.busy        = busy_q;
endmodule
